peripheral_msi_slave_arbiter_ahb3: RTL and testbench

Per-slave arbiter of the MSI AHB3-Lite interconnect. It takes the connection requests (slvHSEL bit, priority, can_switch) from every master port aimed at one slave, selects a single owner, and returns the one-hot `master_granted` vector to the master ports. It also drives the address-phase and data-phase owner indices used by the slave-side multiplexers. Arbitration is highest-priority-first, with round-robin among equal priorities, and ownership is held until the owner reports it can switch.

---
 rtl/peripheral_msi_slave_arbiter_ahb3_if.sv | 28 ++
 rtl/peripheral_msi_slave_arbiter_ahb3.sv | 109 ++++++++++
 tb/tb_peripheral_msi_slave_arbiter_ahb3.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_msi_slave_arbiter_ahb3_if.sv
// Connection bundle between the master ports and one per-slave arbiter:
// requests, priorities and switch hints in; grant and mux owner indices out.
interface peripheral_msi_slave_arbiter_ahb3_if #(
  parameter int unsigned MASTERS = 5
);
  localparam int unsigned MASTER_BITS = $clog2(MASTERS);

  logic [MASTERS-1:0]       mst_req;
  logic [MASTERS-1:0][2:0]  mst_priority;
  logic [MASTERS-1:0]       mst_can_switch;
  logic                     slv_HREADY;
  logic [MASTERS-1:0]       master_granted;
  logic [MASTER_BITS-1:0]   addr_master;
  logic [MASTER_BITS-1:0]   data_master;
  logic                     busy;

  // Arbiter view (it serves the slave)
  modport slave (
    input  mst_req, mst_priority, mst_can_switch, slv_HREADY,
    output master_granted, addr_master, data_master, busy
  );

  // Requesting master-port view
  modport master (
    output mst_req, mst_priority, mst_can_switch, slv_HREADY,
    input  master_granted, addr_master, data_master, busy
  );
endinterface

// File: rtl/peripheral_msi_slave_arbiter_ahb3.sv
// Per-slave arbiter: highest priority first, round-robin among equal priorities,
// ownership held until the owner signals it can switch during an HREADY cycle.
module peripheral_msi_slave_arbiter_ahb3 #(
  parameter int unsigned MASTERS = 5
) (
  input  logic HRESETn,
  input  logic HCLK,
  peripheral_msi_slave_arbiter_ahb3_if.slave bus
);
  localparam int unsigned MASTER_BITS = $clog2(MASTERS);

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e                 state_q, state_d;
  logic [MASTERS-1:0]     grant_q, grant_d;
  logic [MASTER_BITS-1:0] addr_q, addr_d;
  logic [MASTER_BITS-1:0] data_q, data_d;
  logic [MASTER_BITS-1:0] rr_q, rr_d;
  logic                   busy_q, busy_d;

  logic [2:0]             maxp;
  logic [MASTER_BITS-1:0] winner;
  logic                   found;
  logic [MASTER_BITS-1:0] sel;
  int unsigned            idx;
  logic                   any_req;
  logic                   switch_ok;

  assign any_req   = |bus.mst_req;
  assign switch_ok = bus.mst_can_switch[addr_q] & bus.slv_HREADY;

  // Winner: top priority among requesters, first hit after rr_q (owner searched last)
  always_comb begin
    maxp   = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (bus.mst_req[i] && (bus.mst_priority[i] > maxp)) maxp = bus.mst_priority[i];
    end
    for (int unsigned k = 1; k <= MASTERS; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= MASTERS) idx = idx - MASTERS;
      sel = MASTER_BITS'(idx);
      if (!found && bus.mst_req[sel] && (bus.mst_priority[sel] == maxp)) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rr_q    <= MASTER_BITS'(MASTERS - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    rr_d    = rr_q;
    data_d  = data_q;
    // Data phase follows the address phase once the slave accepts a transfer
    if (bus.slv_HREADY && (state_q == GRANTED)) data_d = addr_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = MASTERS'(1) << winner;
          addr_d  = winner;
          rr_d    = winner;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (switch_ok) begin
          if (any_req) begin
            grant_d = MASTERS'(1) << winner;
            addr_d  = winner;
            rr_d    = winner;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = |grant_d;
  end

  assign bus.master_granted = grant_q;
  assign bus.addr_master    = addr_q;
  assign bus.data_master    = data_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_peripheral_msi_slave_arbiter_ahb3.sv
// Directed scenarios for the per-slave arbiter; expected outputs are queued
// when each cycle's inputs are driven and checked one edge later.
module tb_peripheral_msi_slave_arbiter_ahb3;
  localparam int unsigned MASTERS = 5;

  typedef struct packed {
    logic [4:0] req;
    logic [4:0] cs;
    logic       hr;
    logic [4:0] grant;
    logic [2:0] addr;
    logic [2:0] data;
  } step_t;

  typedef struct packed {
    logic [4:0] grant;
    logic [2:0] addr;
    logic [2:0] data;
    logic       busy;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  int   n_vec;
  int   n_err;
  exp_t exp_q[$];
  exp_t e;
  exp_t obs;

  peripheral_msi_slave_arbiter_ahb3_if #(.MASTERS(MASTERS)) bus ();

  peripheral_msi_slave_arbiter_ahb3 #(.MASTERS(MASTERS)) dut (
    .HRESETn(HRESETn),
    .HCLK   (HCLK),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic apply_reset();
    HRESETn              = 1'b0;
    bus.mst_req          = '0;
    bus.mst_can_switch   = '0;
    bus.slv_HREADY       = 1'b1;
    bus.mst_priority     = '0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn            = 1'b0;
    bus.mst_req        = 5'b10100;
    bus.mst_priority   = {5{3'd3}};
    bus.mst_can_switch = '0;
    bus.slv_HREADY     = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    exp_q.push_back('{5'b00000, 3'd0, 3'd0, 1'b0});
    obs = {bus.master_granted, bus.addr_master, bus.data_master, bus.busy};
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL test_reset in_reset: got grant=%b addr=%0d data=%0d busy=%b, want grant=%b addr=%0d data=%0d busy=%b",
               obs.grant, obs.addr, obs.data, obs.busy, e.grant, e.addr, e.data, e.busy);
    end
    HRESETn = 1'b1;
    exp_q.push_back('{5'b00100, 3'd2, 3'd0, 1'b1});
    @(posedge HCLK); #1;
    obs = {bus.master_granted, bus.addr_master, bus.data_master, bus.busy};
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL test_reset first_grant: got grant=%b addr=%0d data=%0d busy=%b, want grant=%b addr=%0d data=%0d busy=%b",
               obs.grant, obs.addr, obs.data, obs.busy, e.grant, e.addr, e.data, e.busy);
    end
  endtask

  task automatic test_round_robin();
    step_t t [4];
    t = '{'{5'b01011, 5'b11111, 1'b1, 5'b00001, 3'd0, 3'd0},
          '{5'b01011, 5'b11111, 1'b1, 5'b00010, 3'd1, 3'd0},
          '{5'b01011, 5'b11111, 1'b1, 5'b01000, 3'd3, 3'd1},
          '{5'b01011, 5'b11111, 1'b1, 5'b00001, 3'd0, 3'd3}};
    apply_reset();
    bus.mst_priority = {5{3'd2}};
    foreach (t[i]) begin
      bus.mst_req = t[i].req; bus.mst_can_switch = t[i].cs; bus.slv_HREADY = t[i].hr;
      exp_q.push_back('{t[i].grant, t[i].addr, t[i].data, t[i].grant != 5'b0});
      @(posedge HCLK); #1;
      obs = {bus.master_granted, bus.addr_master, bus.data_master, bus.busy};
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL test_round_robin step %0d: got grant=%b addr=%0d data=%0d busy=%b, want grant=%b addr=%0d data=%0d busy=%b",
                 i, obs.grant, obs.addr, obs.data, obs.busy, e.grant, e.addr, e.data, e.busy);
      end
    end
  endtask

  task automatic test_priority();
    step_t t [2];
    t = '{'{5'b10010, 5'b00000, 1'b1, 5'b10000, 3'd4, 3'd0},
          '{5'b00010, 5'b11111, 1'b1, 5'b00010, 3'd1, 3'd4}};
    apply_reset();
    bus.mst_priority    = '0;
    bus.mst_priority[1] = 3'd5;
    bus.mst_priority[4] = 3'd6;
    foreach (t[i]) begin
      bus.mst_req = t[i].req; bus.mst_can_switch = t[i].cs; bus.slv_HREADY = t[i].hr;
      exp_q.push_back('{t[i].grant, t[i].addr, t[i].data, t[i].grant != 5'b0});
      @(posedge HCLK); #1;
      obs = {bus.master_granted, bus.addr_master, bus.data_master, bus.busy};
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL test_priority step %0d: got grant=%b addr=%0d data=%0d busy=%b, want grant=%b addr=%0d data=%0d busy=%b",
                 i, obs.grant, obs.addr, obs.data, obs.busy, e.grant, e.addr, e.data, e.busy);
      end
    end
  endtask

  // Owner 2 holds without can_switch, even after dropping its own request
  task automatic test_hold();
    step_t t [6];
    t = '{'{5'b00100, 5'b00000, 1'b1, 5'b00100, 3'd2, 3'd0},
          '{5'b00101, 5'b00000, 1'b1, 5'b00100, 3'd2, 3'd2},
          '{5'b00101, 5'b00000, 1'b1, 5'b00100, 3'd2, 3'd2},
          '{5'b00001, 5'b00000, 1'b1, 5'b00100, 3'd2, 3'd2},
          '{5'b00001, 5'b00000, 1'b1, 5'b00100, 3'd2, 3'd2},
          '{5'b00001, 5'b00100, 1'b1, 5'b00001, 3'd0, 3'd2}};
    apply_reset();
    bus.mst_priority    = '0;
    bus.mst_priority[0] = 3'd7;
    bus.mst_priority[2] = 3'd3;
    foreach (t[i]) begin
      bus.mst_req = t[i].req; bus.mst_can_switch = t[i].cs; bus.slv_HREADY = t[i].hr;
      exp_q.push_back('{t[i].grant, t[i].addr, t[i].data, t[i].grant != 5'b0});
      @(posedge HCLK); #1;
      obs = {bus.master_granted, bus.addr_master, bus.data_master, bus.busy};
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL test_hold step %0d: got grant=%b addr=%0d data=%0d busy=%b, want grant=%b addr=%0d data=%0d busy=%b",
                 i, obs.grant, obs.addr, obs.data, obs.busy, e.grant, e.addr, e.data, e.busy);
      end
    end
  endtask

  // Stalled slave blocks handover and freezes data_master
  task automatic test_stall();
    step_t t [6];
    t = '{'{5'b00001, 5'b11111, 1'b1, 5'b00001, 3'd0, 3'd0},
          '{5'b00100, 5'b11111, 1'b1, 5'b00100, 3'd2, 3'd0},
          '{5'b00101, 5'b11111, 1'b0, 5'b00100, 3'd2, 3'd0},
          '{5'b00101, 5'b11111, 1'b0, 5'b00100, 3'd2, 3'd0},
          '{5'b00101, 5'b11111, 1'b0, 5'b00100, 3'd2, 3'd0},
          '{5'b00101, 5'b11111, 1'b1, 5'b00001, 3'd0, 3'd2}};
    apply_reset();
    bus.mst_priority = {5{3'd3}};
    foreach (t[i]) begin
      bus.mst_req = t[i].req; bus.mst_can_switch = t[i].cs; bus.slv_HREADY = t[i].hr;
      exp_q.push_back('{t[i].grant, t[i].addr, t[i].data, t[i].grant != 5'b0});
      @(posedge HCLK); #1;
      obs = {bus.master_granted, bus.addr_master, bus.data_master, bus.busy};
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL test_stall step %0d: got grant=%b addr=%0d data=%0d busy=%b, want grant=%b addr=%0d data=%0d busy=%b",
                 i, obs.grant, obs.addr, obs.data, obs.busy, e.grant, e.addr, e.data, e.busy);
      end
    end
  endtask

  task automatic test_release_and_async_reset();
    step_t t [5];
    t = '{'{5'b00010, 5'b11111, 1'b1, 5'b00010, 3'd1, 3'd0},
          '{5'b00000, 5'b11111, 1'b1, 5'b00000, 3'd1, 3'd1},
          '{5'b00000, 5'b11111, 1'b1, 5'b00000, 3'd1, 3'd1},
          '{5'b01000, 5'b11111, 1'b1, 5'b01000, 3'd3, 3'd1},
          '{5'b01000, 5'b11111, 1'b1, 5'b01000, 3'd3, 3'd3}};
    apply_reset();
    bus.mst_priority = {5{3'd3}};
    foreach (t[i]) begin
      bus.mst_req = t[i].req; bus.mst_can_switch = t[i].cs; bus.slv_HREADY = t[i].hr;
      exp_q.push_back('{t[i].grant, t[i].addr, t[i].data, t[i].grant != 5'b0});
      @(posedge HCLK); #1;
      obs = {bus.master_granted, bus.addr_master, bus.data_master, bus.busy};
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL test_release step %0d: got grant=%b addr=%0d data=%0d busy=%b, want grant=%b addr=%0d data=%0d busy=%b",
                 i, obs.grant, obs.addr, obs.data, obs.busy, e.grant, e.addr, e.data, e.busy);
      end
    end
    // Reset asserted between edges must clear outputs immediately
    #2 HRESETn = 1'b0;
    exp_q.push_back('{5'b00000, 3'd0, 3'd0, 1'b0});
    #1;
    obs = {bus.master_granted, bus.addr_master, bus.data_master, bus.busy};
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL test_async_reset: got grant=%b addr=%0d data=%0d busy=%b, want grant=%b addr=%0d data=%0d busy=%b",
               obs.grant, obs.addr, obs.data, obs.busy, e.grant, e.addr, e.data, e.busy);
    end
    @(posedge HCLK); #1 HRESETn = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_round_robin();
    test_priority();
    test_hold();
    test_stall();
    test_release_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
